// File: rtl/line_fill_unit_pkg.sv
// Shared widths, address field helpers and FSM state type for the instruction-cache line fill unit.
package line_fill_unit_pkg;

    localparam int unsigned ADDR_WIDTH        = 16;
    localparam int unsigned WORD_WIDTH        = 20;
    localparam int unsigned NUM_WORDS_P_BLOCK = 16;
    localparam int unsigned OFFSET_W          = $clog2(NUM_WORDS_P_BLOCK);
    localparam int unsigned BLOCK_DATA_WIDTH  = NUM_WORDS_P_BLOCK * WORD_WIDTH;
    localparam int unsigned INDEX_WIDTH       = 6;
    localparam int unsigned TAG_WIDTH         = ADDR_WIDTH - INDEX_WIDTH - OFFSET_W;
    localparam int unsigned RCVD_WIDTH        = OFFSET_W + 1;

    typedef enum logic [1:0] {
        LFU_IDLE  = 2'd0,
        LFU_FILL  = 2'd1,
        LFU_WRITE = 2'd2,
        LFU_DONE  = 2'd3
    } lfu_state_e;

    // Word address layout: tag | index | offset
    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFFSET_W +: INDEX_WIDTH];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/line_fill_unit_if.sv
// Miss request, memory block and cache-array write bundle of the line fill unit.
interface line_fill_unit_if;
    import line_fill_unit_pkg::*;

    logic                          i_halt;
    logic [ADDR_WIDTH-1:0]         i_miss_addr;
    logic                          i_miss_addr_valid;
    logic                          o_miss_ready;
    logic [BLOCK_DATA_WIDTH-1:0]   i_mem_block_data;
    logic [RCVD_WIDTH-1:0]         i_mem_num_words_rcvd;
    logic                          i_mem_data_received;
    logic [WORD_WIDTH-1:0]         o_fwd_word;
    logic                          o_fwd_word_valid;
    logic                          o_wr_en;
    logic [INDEX_WIDTH-1:0]        o_wr_index;
    logic [TAG_WIDTH-1:0]          o_wr_tag;
    logic [BLOCK_DATA_WIDTH-1:0]   o_wr_data;
    logic                          o_fill_done;
    logic                          o_busy;

    modport slave (
        input  i_halt, i_miss_addr, i_miss_addr_valid,
               i_mem_block_data, i_mem_num_words_rcvd, i_mem_data_received,
        output o_miss_ready, o_fwd_word, o_fwd_word_valid,
               o_wr_en, o_wr_index, o_wr_tag, o_wr_data, o_fill_done, o_busy
    );

    modport master (
        output i_halt, i_miss_addr, i_miss_addr_valid,
               i_mem_block_data, i_mem_num_words_rcvd, i_mem_data_received,
        input  o_miss_ready, o_fwd_word, o_fwd_word_valid,
               o_wr_en, o_wr_index, o_wr_tag, o_wr_data, o_fill_done, o_busy
    );

endinterface

// File: rtl/line_fill_unit_block_word_mux.sv
// block_word_mux: selects one instruction word from a cache block by word offset; shared with the hit path.
module block_word_mux
    import line_fill_unit_pkg::*;
(
    input  logic [BLOCK_DATA_WIDTH-1:0] block,
    input  logic [OFFSET_W-1:0]         offset,
    output logic [WORD_WIDTH-1:0]       word
);

    always_comb begin
        word = '0;
        case (offset)
            4'd0:  word = block[ 0*WORD_WIDTH +: WORD_WIDTH];
            4'd1:  word = block[ 1*WORD_WIDTH +: WORD_WIDTH];
            4'd2:  word = block[ 2*WORD_WIDTH +: WORD_WIDTH];
            4'd3:  word = block[ 3*WORD_WIDTH +: WORD_WIDTH];
            4'd4:  word = block[ 4*WORD_WIDTH +: WORD_WIDTH];
            4'd5:  word = block[ 5*WORD_WIDTH +: WORD_WIDTH];
            4'd6:  word = block[ 6*WORD_WIDTH +: WORD_WIDTH];
            4'd7:  word = block[ 7*WORD_WIDTH +: WORD_WIDTH];
            4'd8:  word = block[ 8*WORD_WIDTH +: WORD_WIDTH];
            4'd9:  word = block[ 9*WORD_WIDTH +: WORD_WIDTH];
            4'd10: word = block[10*WORD_WIDTH +: WORD_WIDTH];
            4'd11: word = block[11*WORD_WIDTH +: WORD_WIDTH];
            4'd12: word = block[12*WORD_WIDTH +: WORD_WIDTH];
            4'd13: word = block[13*WORD_WIDTH +: WORD_WIDTH];
            4'd14: word = block[14*WORD_WIDTH +: WORD_WIDTH];
            4'd15: word = block[15*WORD_WIDTH +: WORD_WIDTH];
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/line_fill_unit.sv
// Line fill unit: latches a missing address, forwards the critical word and writes the filled block.
// Define CRITICAL_WORD_FWD_EN to forward the critical word as soon as it has arrived (early restart).
module line_fill_unit
    import line_fill_unit_pkg::*;
(
    input  logic           clk,
    input  logic           arst,
    line_fill_unit_if.slave lfu
);

    lfu_state_e                  state;
    logic [TAG_WIDTH-1:0]        tag_q;
    logic [INDEX_WIDTH-1:0]      index_q;
    logic [OFFSET_W-1:0]         offset_q;
    logic                        fwd_done;
    logic [BLOCK_DATA_WIDTH-1:0] block_q;

    logic                        run;
    logic                        early_fwd;
    logic                        fwd_fire;
    logic                        wr_active;
    logic [BLOCK_DATA_WIDTH-1:0] fwd_src;
    logic [WORD_WIDTH-1:0]       sel_word;

    assign run = ~lfu.i_halt;

`ifdef CRITICAL_WORD_FWD_EN
    assign early_fwd = (state == LFU_FILL) &&
                       ({1'b0, offset_q} < lfu.i_mem_num_words_rcvd);
`else
    logic rcvd_unused;
    assign rcvd_unused = ^lfu.i_mem_num_words_rcvd;
    assign early_fwd   = 1'b0;
`endif

    // A forward missed in FILL is made up in WRITE from the frozen block copy.
    assign wr_active = (state == LFU_WRITE);
    assign fwd_fire  = run && !fwd_done && (early_fwd || wr_active);
    assign fwd_src   = wr_active ? block_q : lfu.i_mem_block_data;

    block_word_mux u_word_mux (
        .block  (fwd_src),
        .offset (offset_q),
        .word   (sel_word)
    );

    assign lfu.o_miss_ready     = (state == LFU_IDLE) && run && !arst;
    assign lfu.o_busy           = (state != LFU_IDLE);
    assign lfu.o_fwd_word_valid = fwd_fire;
    assign lfu.o_fwd_word       = fwd_fire ? sel_word : '0;
    assign lfu.o_wr_en          = wr_active && run;
    assign lfu.o_wr_index       = wr_active ? index_q : '0;
    assign lfu.o_wr_tag         = wr_active ? tag_q : '0;
    assign lfu.o_wr_data        = wr_active ? block_q : '0;
    assign lfu.o_fill_done      = (state == LFU_DONE) && run;

    // Halt freezes everything; the pulses above then recur on the next running cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= LFU_IDLE;
            tag_q    <= '0;
            index_q  <= '0;
            offset_q <= '0;
            fwd_done <= 1'b0;
            block_q  <= '0;
        end else if (run) begin
            if (fwd_fire) begin
                fwd_done <= 1'b1;
            end
            case (state)
                LFU_IDLE: begin
                    if (lfu.i_miss_addr_valid) begin
                        state    <= LFU_FILL;
                        tag_q    <= addr_tag(lfu.i_miss_addr);
                        index_q  <= addr_index(lfu.i_miss_addr);
                        offset_q <= addr_offset(lfu.i_miss_addr);
                        fwd_done <= 1'b0;
                    end
                end
                LFU_FILL: begin
                    if (lfu.i_mem_data_received) begin
                        state   <= LFU_WRITE;
                        block_q <= lfu.i_mem_block_data;
                    end
                end
                LFU_WRITE: state <= LFU_DONE;
                LFU_DONE:  state <= LFU_IDLE;
                default:   state <= LFU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: reset, table-driven fills, hand corner cases, random fills vs a rule model.
module tb_line_fill_unit;
    import line_fill_unit_pkg::*;

`ifdef CRITICAL_WORD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    line_fill_unit_if u_if();

    line_fill_unit u_dut (
        .clk  (clk),
        .arst (arst),
        .lfu  (u_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_WIDTH-1:0]  addr;
        logic [TAG_WIDTH-1:0]   tag;
        logic [INDEX_WIDTH-1:0] idx;
        int unsigned            off;
        int                     fwd_stage;  // stage (rcvd = 4*stage) of the early forward
    } vec_t;

    vec_t vecs[5];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [BLOCK_DATA_WIDTH-1:0] act,
                        input logic [BLOCK_DATA_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BLOCK_DATA_WIDTH-1:0] rand_block();
        logic [BLOCK_DATA_WIDTH-1:0] b;
        for (int i = 0; i < 10; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    function automatic logic [WORD_WIDTH-1:0] word_of(input logic [BLOCK_DATA_WIDTH-1:0] b,
                                                      input int unsigned off);
        return b[off*WORD_WIDTH +: WORD_WIDTH];
    endfunction

    task automatic drive(input logic halt, input logic valid, input logic [ADDR_WIDTH-1:0] addr,
                         input logic [BLOCK_DATA_WIDTH-1:0] data, input logic [RCVD_WIDTH-1:0] rcvd,
                         input logic drx);
        u_if.i_halt               = halt;
        u_if.i_miss_addr_valid    = valid;
        u_if.i_miss_addr          = addr;
        u_if.i_mem_block_data     = data;
        u_if.i_mem_num_words_rcvd = rcvd;
        u_if.i_mem_data_received  = drx;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Fill with rcvd stepping 0,4,8,12,16 (data_received with 16), then write, done, idle.
    task automatic run_vec(input vec_t v, input string tag);
        logic [BLOCK_DATA_WIDTH-1:0] blk;
        int exp_stage;
        blk = rand_block();
        exp_stage = FWD_EN ? v.fwd_stage : 5;
        drive(1'b0, 1'b1, v.addr, blk, 5'd0, 1'b0);
        #4;
        chk1({tag, "_accept_ready"}, u_if.o_miss_ready, 1'b1);
        next_cycle();
        for (int s = 0; s < 8; s++) begin
            if (s <= 4) drive(1'b0, 1'b0, '0, blk, 5'(4*s), s == 4);
            else        drive(1'b0, 1'b0, '0, ~blk, 5'd0, 1'b0);
            #4;
            chk1({tag, "_fwd_valid"}, u_if.o_fwd_word_valid, s == exp_stage);
            if (s == exp_stage)
                chkv({tag, "_fwd_word"}, 320'(u_if.o_fwd_word), 320'(word_of(blk, v.off)));
            chk1({tag, "_wr_en"}, u_if.o_wr_en, s == 5);
            if (s == 5) begin
                chkv({tag, "_wr_index"}, 320'(u_if.o_wr_index), 320'(v.idx));
                chkv({tag, "_wr_tag"}, 320'(u_if.o_wr_tag), 320'(v.tag));
                chkv({tag, "_wr_data"}, u_if.o_wr_data, blk);
            end
            chk1({tag, "_fill_done"}, u_if.o_fill_done, s == 6);
            chk1({tag, "_busy"}, u_if.o_busy, s <= 6);
            next_cycle();
        end
    endtask

    // Random fill: plan per-cycle stimulus, derive expected event cycles from the rules, then replay.
    task automatic run_random();
        logic                        halt_p[80];
        logic [RCVD_WIDTH-1:0]       rcvd_p[80];
        logic                        drx_p[80];
        logic                        mv_p[80];
        logic [BLOCK_DATA_WIDTH-1:0] blk;
        logic [ADDR_WIDTH-1:0]       addr;
        int unsigned                 off;
        int d, fwd_k, wr_k, done_k, r;

        addr = ADDR_WIDTH'($urandom());
        off  = int'(addr[3:0]);
        blk  = rand_block();
        d = -1; r = 0;
        for (int k = 0; k < 80; k++) begin
            halt_p[k] = ($urandom_range(3) == 0);
            mv_p[k]   = $urandom_range(1) == 1;
            drx_p[k]  = 1'b0;
            if (d < 0) begin
                if (k > 0 && r < 16 && ($urandom_range(2) == 0 || k >= 40)) r += 4;
                if (k >= 50) halt_p[k] = 1'b0;
                rcvd_p[k] = 5'(r);
                if (r == 16 && !halt_p[k] && ($urandom_range(1) == 0 || k >= 50)) begin
                    drx_p[k] = 1'b1;
                    d = k;
                end
            end else begin
                rcvd_p[k] = 5'($urandom_range(16));
                drx_p[k]  = $urandom_range(1) == 1;
                if (k >= d + 8) halt_p[k] = 1'b0;
            end
        end

        fwd_k = -1;
        if (FWD_EN)
            for (int k = 0; k <= d; k++)
                if (fwd_k < 0 && !halt_p[k] && off < int'(rcvd_p[k])) fwd_k = k;
        wr_k = -1;
        for (int k = d + 1; k < 80; k++) if (wr_k < 0 && !halt_p[k]) wr_k = k;
        done_k = -1;
        for (int k = wr_k + 1; k < 80; k++) if (done_k < 0 && !halt_p[k]) done_k = k;
        if (fwd_k < 0) fwd_k = wr_k;

        drive(1'b0, 1'b1, addr, blk, 5'd0, 1'b0);
        next_cycle();
        for (int k = 0; k <= done_k + 1; k++) begin
            drive(halt_p[k], (k <= done_k) ? mv_p[k] : 1'b0, ADDR_WIDTH'($urandom()),
                  (k <= d) ? blk : rand_block(), rcvd_p[k], drx_p[k]);
            #4;
            chk1("rnd_miss_ready", u_if.o_miss_ready, k > done_k && !halt_p[k]);
            chk1("rnd_fwd_valid", u_if.o_fwd_word_valid, k == fwd_k);
            if (k == fwd_k)
                chkv("rnd_fwd_word", 320'(u_if.o_fwd_word), 320'(word_of(blk, off)));
            chk1("rnd_wr_en", u_if.o_wr_en, k == wr_k);
            if (k == wr_k) begin
                chkv("rnd_wr_index", 320'(u_if.o_wr_index), 320'(addr[9:4]));
                chkv("rnd_wr_tag", 320'(u_if.o_wr_tag), 320'(addr[15:10]));
                chkv("rnd_wr_data", u_if.o_wr_data, blk);
            end
            chk1("rnd_fill_done", u_if.o_fill_done, k == done_k);
            chk1("rnd_busy", u_if.o_busy, k <= done_k);
            next_cycle();
        end
    endtask

    initial begin
        logic [BLOCK_DATA_WIDTH-1:0] blk;

        vecs[0] = '{16'h1A37, 6'h06, 6'h23, 7,  2};
        vecs[1] = '{16'h3C0F, 6'h0F, 6'h00, 15, 4};
        vecs[2] = '{16'hFFF0, 6'h3F, 6'h3F, 0,  1};
        vecs[3] = '{16'h0045, 6'h00, 6'h04, 5,  2};
        vecs[4] = '{16'h1232, 6'h04, 6'h23, 2,  1};

        drive(1'b0, 1'b0, '0, '0, 5'd0, 1'b0);
        #2 arst = 1'b1;
        #10;
        chk1("rst_miss_ready", u_if.o_miss_ready, 1'b0);
        chk1("rst_busy", u_if.o_busy, 1'b0);
        chk1("rst_fwd_valid", u_if.o_fwd_word_valid, 1'b0);
        chk1("rst_wr_en", u_if.o_wr_en, 1'b0);
        chk1("rst_fill_done", u_if.o_fill_done, 1'b0);
        chkv("rst_wr_data", u_if.o_wr_data, '0);
        chkv("rst_fwd_word", 320'(u_if.o_fwd_word), '0);
        next_cycle();
        arst = 1'b0;
        #4;
        chk1("rel_miss_ready", u_if.o_miss_ready, 1'b1);
        chk1("rel_busy", u_if.o_busy, 1'b0);
        next_cycle();

        for (int i = 0; i < 4; i++) run_vec(vecs[i], "tbl");

        // Halt across WRITE, with a second miss offered while busy.
        blk = rand_block();
        drive(1'b0, 1'b1, 16'h2481, blk, 5'd0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, 16'h0FFF, blk, 5'd16, 1'b1);
        #4;
        chk1("halt_busy_ready", u_if.o_miss_ready, 1'b0);
        chk1("halt_fill_fwd", u_if.o_fwd_word_valid, FWD_EN);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'h0FFF, ~blk, 5'd0, 1'b0);
            #4;
            chk1("halt_wr_en", u_if.o_wr_en, 1'b0);
            chk1("halt_fwd", u_if.o_fwd_word_valid, 1'b0);
            chk1("halt_done", u_if.o_fill_done, 1'b0);
            chk1("halt_busy", u_if.o_busy, 1'b1);
            next_cycle();
        end
        drive(1'b0, 1'b1, 16'h0FFF, ~blk, 5'd0, 1'b0);
        #4;
        chk1("unhalt_wr_en", u_if.o_wr_en, 1'b1);
        chk1("unhalt_fwd", u_if.o_fwd_word_valid, !FWD_EN);
        chkv("unhalt_wr_index", 320'(u_if.o_wr_index), 320'(6'h08));
        chkv("unhalt_wr_tag", 320'(u_if.o_wr_tag), 320'(6'h09));
        chkv("unhalt_wr_data", u_if.o_wr_data, blk);
        next_cycle();
        drive(1'b0, 1'b0, '0, ~blk, 5'd0, 1'b0);
        #4;
        chk1("unhalt_done", u_if.o_fill_done, 1'b1);
        chk1("unhalt_wr_off", u_if.o_wr_en, 1'b0);
        next_cycle();
        #4;
        chk1("unhalt_idle_busy", u_if.o_busy, 1'b0);
        chk1("unhalt_idle_ready", u_if.o_miss_ready, 1'b1);
        next_cycle();

        // Asynchronous reset in the middle of a fill.
        blk = rand_block();
        drive(1'b0, 1'b1, 16'h5679, blk, 5'd0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, '0, blk, 5'd4, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, '0, blk, 5'd8, 1'b0);
        #4;
        chk1("arst_pre_fwd", u_if.o_fwd_word_valid, 1'b0);
        chk1("arst_pre_busy", u_if.o_busy, 1'b1);
        next_cycle();
        arst = 1'b1;
        #4;
        chk1("arst_busy", u_if.o_busy, 1'b0);
        chk1("arst_ready", u_if.o_miss_ready, 1'b0);
        next_cycle();
        arst = 1'b0;
        drive(1'b0, 1'b0, '0, blk, 5'd16, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #4;
            chk1("arst_no_wr", u_if.o_wr_en, 1'b0);
            chk1("arst_no_done", u_if.o_fill_done, 1'b0);
            chk1("arst_no_fwd", u_if.o_fwd_word_valid, 1'b0);
            chk1("arst_idle", u_if.o_busy, 1'b0);
            next_cycle();
            drive(1'b0, 1'b0, '0, blk, 5'd0, 1'b0);
        end
        run_vec(vecs[4], "post_arst");

        for (int i = 0; i < 40; i++) run_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
